// File: rtl/riscv_sim_harness_ctrl.sv
// riscv_sim_harness_ctrl
// Run controller for multi-core RISC-V simulation / FPGA test harnesses.
// It releases reset in stages (test memory first, then the cores) and waits for
// run_en. It then monitors each core's CSR status word and counts run cycles and
// retired instructions per core. Finally it reports a sticky pass/fail/timeout
// verdict.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   run_en           start request, sampled in IDLE only
//   max_cycles       timeout threshold (0 disables)
//   stats_en         gates cycle / instruction counting
//   csr_status       per-core 32-bit status words, core i at [32i+31:32i]
//   inst_val         per-core retire pulse
//   stat_sel         core index for stat_num_inst
//   reset_mem        active-high reset to test memory
//   reset_proc       active-high reset per core
//   done             verdict valid (sticky)
//   pass             all cores reported status 1
//   timeout          cycle limit exceeded
//   fail_core        index of the first failing core
//   fail_code        status value of the first failing core
//   num_cycles       RUN-state cycle count
//   stat_num_inst    retired count of core stat_sel (0 when out of range)
module riscv_sim_harness_ctrl #(
    parameter int unsigned p_num_cores      = 2,
    parameter int unsigned p_cnt_sz         = 32,
    parameter int unsigned p_rst_mem_cycles = 4,
    parameter int unsigned p_drain_cycles   = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      run_en,
    input  logic [p_cnt_sz-1:0]       max_cycles,
    input  logic                      stats_en,
    input  logic [p_num_cores*32-1:0] csr_status,
    input  logic [p_num_cores-1:0]    inst_val,
    input  logic [3:0]                stat_sel,
    output logic                      reset_mem,
    output logic [p_num_cores-1:0]    reset_proc,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [3:0]                fail_core,
    output logic [31:0]               fail_code,
    output logic [p_cnt_sz-1:0]       num_cycles,
    output logic [p_cnt_sz-1:0]       stat_num_inst
);

    localparam int unsigned STG_MAX = (p_rst_mem_cycles > p_drain_cycles) ?
                                      p_rst_mem_cycles : p_drain_cycles;
    localparam int unsigned STG_W   = $clog2(STG_MAX + 1);
    localparam logic [p_cnt_sz-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_RST_MEM  = 3'd0,
        ST_RST_PROC = 3'd1,
        ST_IDLE     = 3'd2,
        ST_RUN      = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t                   state_q,      state_d;
    logic [STG_W-1:0]         stg_cnt_q,    stg_cnt_d;
    logic                     reset_mem_q,  reset_mem_d;
    logic [p_num_cores-1:0]   reset_proc_q, reset_proc_d;
    logic                     done_q,       done_d;
    logic                     pass_q,       pass_d;
    logic                     timeout_q,    timeout_d;
    logic [3:0]               fail_core_q,  fail_core_d;
    logic [31:0]              fail_code_q,  fail_code_d;
    logic [p_cnt_sz-1:0]      cyc_cnt_q,    cyc_cnt_d;
    logic [p_cnt_sz-1:0]      inst_cnt_q [p_num_cores];
    logic [p_cnt_sz-1:0]      inst_cnt_d [p_num_cores];
    logic [31:0]              stat_q     [p_num_cores];
    logic [31:0]              stat_d     [p_num_cores];
    logic [p_num_cores-1:0]   fin_q,        fin_d;

    // Verdict terms evaluated on the post-edge (next-state) view of the run.
    logic                     fail_hit;
    logic [3:0]               fail_idx;
    logic [31:0]              fail_val;
    logic                     all_pass;
    logic                     tmo_hit;

    // Next-state, counter and verdict logic.
    always_comb begin
        state_d      = state_q;
        stg_cnt_d    = stg_cnt_q;
        reset_mem_d  = reset_mem_q;
        reset_proc_d = reset_proc_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        fail_core_d  = fail_core_q;
        fail_code_d  = fail_code_q;
        cyc_cnt_d    = cyc_cnt_q;
        inst_cnt_d   = inst_cnt_q;
        stat_d       = stat_q;
        fin_d        = fin_q;
        fail_hit     = 1'b0;
        fail_idx     = 4'd0;
        fail_val     = 32'd0;
        all_pass     = 1'b0;
        tmo_hit      = 1'b0;

        case (state_q)
            ST_RST_MEM: begin
                reset_mem_d  = 1'b1;
                reset_proc_d = '1;
                if (stg_cnt_q == STG_W'(p_rst_mem_cycles - 1)) begin
                    state_d     = ST_RST_PROC;
                    stg_cnt_d   = '0;
                    reset_mem_d = 1'b0;
                end else begin
                    stg_cnt_d = stg_cnt_q + STG_W'(1);
                end
            end

            ST_RST_PROC: begin
                state_d      = ST_IDLE;
                reset_proc_d = '0;
            end

            ST_IDLE: begin
                if (run_en) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Saturating counters, gated by stats_en.
                if (stats_en) begin
                    if (cyc_cnt_q != CNT_MAX) begin
                        cyc_cnt_d = cyc_cnt_q + p_cnt_sz'(1);
                    end
                    for (int i = 0; i < int'(p_num_cores); i++) begin
                        if (inst_val[i] && (inst_cnt_q[i] != CNT_MAX)) begin
                            inst_cnt_d[i] = inst_cnt_q[i] + p_cnt_sz'(1);
                        end
                    end
                end

                // First nonzero status per core is latched; later values are ignored.
                for (int i = 0; i < int'(p_num_cores); i++) begin
                    if (!fin_q[i] && (csr_status[32*i +: 32] != 32'd0)) begin
                        fin_d[i]  = 1'b1;
                        stat_d[i] = csr_status[32*i +: 32];
                    end
                end

                // Scan high to low so the lowest failing index is the one kept.
                for (int i = int'(p_num_cores) - 1; i >= 0; i--) begin
                    if (stat_d[i] > 32'd1) begin
                        fail_hit = 1'b1;
                        fail_idx = 4'(i);
                        fail_val = stat_d[i];
                    end
                end

                all_pass = 1'b1;
                for (int i = 0; i < int'(p_num_cores); i++) begin
                    if (stat_d[i] != 32'd1) begin
                        all_pass = 1'b0;
                    end
                end

                tmo_hit = (max_cycles != '0) && (cyc_cnt_d > max_cycles);

                if (fail_hit) begin
                    fail_core_d = fail_idx;
                    fail_code_d = fail_val;
                end
                if (tmo_hit) begin
                    timeout_d = 1'b1;
                end
                if (all_pass && !tmo_hit) begin
                    pass_d = 1'b1;
                end
                if (fail_hit || tmo_hit || all_pass) begin
                    state_d   = ST_DRAIN;
                    stg_cnt_d = '0;
                end
            end

            ST_DRAIN: begin
                if (stg_cnt_q == STG_W'(p_drain_cycles - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    stg_cnt_d = stg_cnt_q + STG_W'(1);
                end
            end

            ST_DONE: begin
                done_d = 1'b1;
            end

            default: begin
                state_d = ST_RST_MEM;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RST_MEM;
            stg_cnt_q    <= '0;
            reset_mem_q  <= 1'b1;
            reset_proc_q <= '1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_core_q  <= 4'd0;
            fail_code_q  <= 32'd0;
            cyc_cnt_q    <= '0;
            inst_cnt_q   <= '{default: '0};
            stat_q       <= '{default: '0};
            fin_q        <= '0;
        end else begin
            state_q      <= state_d;
            stg_cnt_q    <= stg_cnt_d;
            reset_mem_q  <= reset_mem_d;
            reset_proc_q <= reset_proc_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fail_core_q  <= fail_core_d;
            fail_code_q  <= fail_code_d;
            cyc_cnt_q    <= cyc_cnt_d;
            inst_cnt_q   <= inst_cnt_d;
            stat_q       <= stat_d;
            fin_q        <= fin_d;
        end
    end

    // Per-core instruction count readout; out-of-range selects read zero.
    always_comb begin
        stat_num_inst = '0;
        for (int i = 0; i < int'(p_num_cores); i++) begin
            if (stat_sel == 4'(i)) begin
                stat_num_inst = inst_cnt_q[i];
            end
        end
    end

    assign reset_mem  = reset_mem_q;
    assign reset_proc = reset_proc_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign fail_core  = fail_core_q;
    assign fail_code  = fail_code_q;
    assign num_cycles = cyc_cnt_q;

endmodule

// File: tb/tb_riscv_sim_harness_ctrl.sv
// Directed bench for riscv_sim_harness_ctrl with a scoreboard of expectations.
module tb_riscv_sim_harness_ctrl;

    localparam int unsigned NC = 2;
    localparam int unsigned CW = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            run_en;
    logic [CW-1:0]   max_cycles;
    logic            stats_en;
    logic [NC*32-1:0] csr_status;
    logic [NC-1:0]   inst_val;
    logic [3:0]      stat_sel;
    logic            reset_mem;
    logic [NC-1:0]   reset_proc;
    logic            done;
    logic            pass;
    logic            timeout;
    logic [3:0]      fail_core;
    logic [31:0]     fail_code;
    logic [CW-1:0]   num_cycles;
    logic [CW-1:0]   stat_num_inst;

    riscv_sim_harness_ctrl #(
        .p_num_cores      (NC),
        .p_cnt_sz         (CW),
        .p_rst_mem_cycles (4),
        .p_drain_cycles   (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run_en        (run_en),
        .max_cycles    (max_cycles),
        .stats_en      (stats_en),
        .csr_status    (csr_status),
        .inst_val      (inst_val),
        .stat_sel      (stat_sel),
        .reset_mem     (reset_mem),
        .reset_proc    (reset_proc),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .fail_core     (fail_core),
        .fail_code     (fail_code),
        .num_cycles    (num_cycles),
        .stat_num_inst (stat_num_inst)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    task automatic expect_val(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        n_vec++;
        if (tag_q.size() == 0) begin
            n_miss++;
            $display("FAIL scoreboard_empty observed=0x%0h required=none", obs);
        end else begin
            tag = tag_q.pop_front();
            exp = val_q.pop_front();
            assert (obs === exp) else begin
                n_miss++;
                $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            end
        end
    endtask

    task automatic wait_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_verdict(input string pfx, input logic [31:0] e_done,
                               input logic [31:0] e_pass, input logic [31:0] e_tmo,
                               input logic [31:0] e_fcore, input logic [31:0] e_fcode,
                               input logic [31:0] e_cyc);
        expect_val({pfx, "_done"},      e_done);
        expect_val({pfx, "_pass"},      e_pass);
        expect_val({pfx, "_timeout"},   e_tmo);
        expect_val({pfx, "_fail_core"}, e_fcore);
        expect_val({pfx, "_fail_code"}, e_fcode);
        expect_val({pfx, "_cycles"},    e_cyc);
        observe(32'(done));
        observe(32'(pass));
        observe(32'(timeout));
        observe(32'(fail_core));
        observe(32'(fail_code));
        observe(32'(num_cycles));
    endtask

    // Mid-cycle reset assertion, immediate check, then staging back to IDLE.
    task automatic do_reset(input string pfx);
        @(negedge clk);
        reset_n    = 1'b0;
        run_en     = 1'b0;
        csr_status = '0;
        inst_val   = '0;
        #1;
        expect_val({pfx, "_rst_mem"},  32'd1);
        expect_val({pfx, "_rst_proc"}, 32'd3);
        observe(32'(reset_mem));
        observe(32'(reset_proc));
        chk_verdict({pfx, "_rst"}, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) wait_sample();
    endtask

    int m0, m1, mc;

    initial begin
        reset_n    = 1'b0;
        run_en     = 1'b0;
        max_cycles = '0;
        stats_en   = 1'b0;
        csr_status = '0;
        inst_val   = '0;
        stat_sel   = 4'd0;

        // Reset state and staged release.
        wait_sample();
        expect_val("por_rst_mem", 32'd1);
        expect_val("por_rst_proc", 32'd3);
        observe(32'(reset_mem));
        observe(32'(reset_proc));
        chk_verdict("por", 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wait_sample();
            expect_val($sformatf("stage%0d_rst_mem", k), (k < 4) ? 32'd1 : 32'd0);
            expect_val($sformatf("stage%0d_rst_proc", k), (k < 5) ? 32'd3 : 32'd0);
            observe(32'(reset_mem));
            observe(32'(reset_proc));
        end

        // IDLE holds counters while run_en is low.
        stats_en = 1'b1;
        inst_val = 2'b11;
        repeat (3) wait_sample();
        inst_val = '0;
        expect_val("idle_cycles", 32'd0);
        observe(32'(num_cycles));

        // Pass: core0 at cycle 50 (later change ignored), core1 at cycle 80.
        run_en = 1'b1;
        wait_sample();
        run_en = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (c == 50) csr_status[31:0]  = 32'd1;
            if (c == 60) csr_status[31:0]  = 32'd7;
            if (c == 80) csr_status[63:32] = 32'd1;
            wait_sample();
            if (c == 40) chk_verdict("pass_c40", 0, 0, 0, 0, 0, 40);
            if (c == 79) chk_verdict("pass_c79", 0, 0, 0, 0, 0, 79);
        end
        chk_verdict("pass_c80", 0, 1, 0, 0, 0, 80);
        wait_sample();
        expect_val("pass_drain1_done", 32'd0);
        observe(32'(done));
        wait_sample();
        chk_verdict("pass_done", 1, 1, 0, 0, 0, 80);
        csr_status = {32'd5, 32'd5};
        repeat (3) wait_sample();
        chk_verdict("pass_sticky", 1, 1, 0, 0, 0, 80);

        // Simultaneous failures: lowest index wins.
        do_reset("s2");
        max_cycles = '0;
        run_en     = 1'b1;
        wait_sample();
        repeat (3) wait_sample();
        csr_status = {32'd5, 32'd3};
        wait_sample();
        chk_verdict("fail_edge", 0, 0, 0, 0, 3, 4);
        repeat (2) wait_sample();
        chk_verdict("fail_done", 1, 0, 0, 0, 3, 4);

        // Timeout at 101 with max_cycles=100.
        do_reset("s3");
        max_cycles = 32'd100;
        run_en     = 1'b1;
        wait_sample();
        for (int c = 1; c <= 100; c++) wait_sample();
        chk_verdict("tmo_c100", 0, 0, 0, 0, 0, 100);
        wait_sample();
        chk_verdict("tmo_c101", 0, 0, 1, 0, 0, 101);
        repeat (2) wait_sample();
        chk_verdict("tmo_done", 1, 0, 1, 0, 0, 101);

        // Instruction counting with stats_en gating.
        do_reset("s4");
        max_cycles = '0;
        run_en     = 1'b1;
        wait_sample();
        m0 = 0; m1 = 0; mc = 0;
        for (int k = 0; k < 37; k++) begin
            inst_val = {1'b1, (k % 3) == 0};
            stats_en = !(k >= 5 && k < 15);
            if (stats_en) begin
                m1++;
                mc++;
                if ((k % 3) == 0) m0++;
            end
            wait_sample();
        end
        inst_val = '0;
        stats_en = 1'b1;
        repeat (2) wait_sample();
        mc += 2;
        stat_sel = 4'd1;
        #1;
        expect_val("inst_core1", 32'd27);
        observe(32'(stat_num_inst));
        stat_sel = 4'd0;
        #1;
        expect_val("inst_core0", 32'(m0));
        observe(32'(stat_num_inst));
        stat_sel = 4'd5;
        #1;
        expect_val("inst_sel_oob", 32'd0);
        observe(32'(stat_num_inst));
        expect_val("inst_cycles", 32'(mc));
        observe(32'(num_cycles));

        // Core0 passes, core1 still running, then reset mid-run.
        csr_status[31:0] = 32'd1;
        wait_sample();
        chk_verdict("half_pass", 0, 0, 0, 0, 0, 32'(mc + 1));
        do_reset("s5");
        stat_sel = 4'd1;
        #1;
        expect_val("s5_inst_cleared", 32'd0);
        observe(32'(stat_num_inst));

        // Fresh run: latches cleared, then fail and timeout on the same edge.
        max_cycles = 32'd5;
        run_en     = 1'b1;
        wait_sample();
        csr_status[63:32] = 32'd1;
        wait_sample();
        chk_verdict("fresh_c1", 0, 0, 0, 0, 0, 1);
        repeat (4) wait_sample();
        csr_status[31:0] = 32'd9;
        wait_sample();
        chk_verdict("fail_tmo", 0, 0, 1, 0, 9, 6);
        repeat (2) wait_sample();
        chk_verdict("fail_tmo_done", 1, 0, 1, 0, 9, 6);

        // Pass and timeout together: timeout only.
        do_reset("s6");
        max_cycles = 32'd2;
        run_en     = 1'b1;
        wait_sample();
        repeat (2) wait_sample();
        csr_status = {32'd1, 32'd1};
        wait_sample();
        chk_verdict("pass_tmo", 0, 0, 1, 0, 0, 3);
        repeat (2) wait_sample();
        chk_verdict("pass_tmo_done", 1, 0, 1, 0, 0, 3);

        if (tag_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", tag_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
